// File: rtl/cardinal_pkg.sv
// Shared constants for the cardinal branch predictor: opcodes and checkpoint layout helpers.
package cardinal_pkg;

  localparam logic [5:0] R_ALU     = 6'b000000;
  localparam logic [5:0] LOAD      = 6'b100000;
  localparam logic [5:0] STORE     = 6'b101000;
  localparam logic [5:0] BRANCH_EZ = 6'b100010;
  localparam logic [5:0] BRANCH_NZ = 6'b100011;
  localparam logic [5:0] NOP       = 6'b111111;

  // A bimodal build still carries a 1-bit ghr field so every struct member has nonzero width.
  function automatic int ghr_eff(input int ghr_w);
    return (ghr_w > 0) ? ghr_w : 1;
  endfunction

  // Checkpoint entry, MSB first: {idx, pred, target, fallthrough, ghr}.
  function automatic int ckpt_w(input int addr_w, input int idx_w, input int ghr_w);
    return idx_w + 1 + 2 * addr_w + ghr_eff(ghr_w);
  endfunction

endpackage

// File: rtl/cardinal_br_ckpt_fifo.sv
// Checkpoint FIFO for in-flight predicted branches; synchronous clear drops wrong-path entries.
module cardinal_br_ckpt_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (Reset || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset: entries are only read when cnt says they are live.
  always_ff @(posedge Clock) begin
    if (do_push && !Reset && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cardinal_branch_predictor_bht.sv
// Dynamic branch predictor: saturating-counter table (bimodal or gshare) with checkpointed resolve.
module cardinal_branch_predictor_bht
  import cardinal_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = 4,
  parameter int CTR_W    = 2,
  parameter int GHR_W    = 0,
  parameter int INFLIGHT = 2,
  parameter int PERF_W   = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [31:0]       fetch_instr,
  output logic              fetch_ready,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              resolve_err,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);

  localparam int GW   = ghr_eff(GHR_W);
  localparam int NCTR = 1 << IDX_W;
  localparam int EW   = ckpt_w(ADDR_W, IDX_W, GHR_W);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              pred;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fall;
    logic [GW-1:0]     ghr;
  } ckpt_t;

  logic [NCTR-1:0][CTR_W-1:0] ctr;
  logic [GW-1:0]    ghr;
  logic [5:0]       opcode;
  logic [7:0]       tgt8;
  logic             is_br, push, hit, full, empty;
  logic [IDX_W-1:0] idx, ghr_idx;
  ckpt_t            ent, hd;
  logic [EW-1:0]    head_bits;
  logic             unused_instr;

  // Instruction bit 0 is the word MSB, so opcode [0:5] is [31:26] and target [24:31] is [7:0].
  assign opcode       = fetch_instr[31:26];
  assign tgt8         = fetch_instr[7:0];
  assign unused_instr = ^fetch_instr[25:8];
  assign pred_target  = ADDR_W'(tgt8);

  assign is_br   = fetch_valid & ((opcode == BRANCH_EZ) | (opcode == BRANCH_NZ));
  assign ghr_idx = (GHR_W > 0) ? IDX_W'(ghr) : '0;
  assign idx     = fetch_pc[IDX_W-1:0] ^ ghr_idx;

  assign fetch_ready = ~full;
  assign pred_taken  = is_br & fetch_ready & ctr[idx][CTR_W-1];

  assign hd          = head_bits;
  assign hit         = resolve_valid & ~empty;
  assign mispredict  = hit & (hd.pred != resolve_taken);
  assign redirect_pc = hit ? (resolve_taken ? hd.target : hd.fall) : '0;
  assign resolve_err = resolve_valid & empty;

  // Entries younger than a mispredicted head are wrong-path, so a same-cycle push is dropped.
  assign push = is_br & fetch_ready & ~mispredict;

  always_comb begin
    ent        = '0;
    ent.idx    = idx;
    ent.pred   = pred_taken;
    ent.target = pred_target;
    ent.fall   = fetch_pc + ADDR_W'(1);
    ent.ghr    = ghr;
  end

  cardinal_br_ckpt_fifo #(.DEPTH(INFLIGHT), .DATA_W(EW)) u_ckpt (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .pop   (hit),
    .clr   (mispredict),
    .din   (ent),
    .head  (head_bits),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ctr <= {NCTR{CTR_INIT}};
    end else if (hit) begin
      if (resolve_taken && ctr[hd.idx] != '1)
        ctr[hd.idx] <= ctr[hd.idx] + CTR_W'(1);
      else if (!resolve_taken && ctr[hd.idx] != '0)
        ctr[hd.idx] <= ctr[hd.idx] - CTR_W'(1);
    end
  end

  // Speculative history: a mispredict rebuilds from the checkpoint, otherwise a push shifts in.
  always_ff @(posedge Clock) begin
    if (Reset || GHR_W == 0)
      ghr <= '0;
    else if (mispredict)
      ghr <= (hd.ghr << 1) | GW'(resolve_taken);
    else if (push)
      ghr <= (ghr << 1) | GW'(pred_taken);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (hit) begin
      if (branch_cnt != '1)                  branch_cnt  <= branch_cnt + PERF_W'(1);
      if (mispredict && mispred_cnt != '1)   mispred_cnt <= mispred_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_cardinal_branch_predictor_bht.sv
// Randomized scoreboard bench for the branch predictor, using a gshare build with a 2-bit history.
module tb_cardinal_branch_predictor_bht;

  localparam int ADDR_W = 8, IDX_W = 4, CTR_W = 2, GHR_W = 2, INFL = 2, PERF_W = 16;
  localparam int OP_BEZ = 34, OP_BNZ = 35, OP_LOAD = 32, OP_NOP = 63, OP_ALU = 0;

  logic              Clock = 0, Reset = 1;
  logic              fetch_valid = 0, resolve_valid = 0, resolve_taken = 0;
  logic [ADDR_W-1:0] fetch_pc = '0;
  logic [31:0]       fetch_instr = '0;
  logic              fetch_ready, pred_taken, mispredict, resolve_err;
  logic [ADDR_W-1:0] pred_target, redirect_pc;
  logic [PERF_W-1:0] branch_cnt, mispred_cnt;

  cardinal_branch_predictor_bht #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W),
    .INFLIGHT(INFL), .PERF_W(PERF_W)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .pred_taken(pred_taken), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .resolve_err(resolve_err),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 Clock = ~Clock;

  typedef struct { int idx; bit pred; int target; int fall; int ghr; } ent_t;
  typedef struct { bit ready; bit pt; int tgt; bit mp; int rpc; bit err; int bc; int mc; } exp_t;

  ent_t mq[$];
  exp_t sbq[$];
  int   mctr[16];
  int   mghr, mbc, mmc;
  int   n_chk = 0, n_fail = 0;

  task automatic model_reset();
    foreach (mctr[i]) mctr[i] = 1;
    mq.delete();
    mghr = 0; mbc = 0; mmc = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: DUT presents a full output set every non-reset cycle.
  always @(negedge Clock) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("fetch_ready", fetch_ready, e.ready);
      chk("pred_taken",  pred_taken,  e.pt);
      chk("pred_target", pred_target, e.tgt);
      chk("mispredict",  mispredict,  e.mp);
      chk("redirect_pc", redirect_pc, e.rpc);
      chk("resolve_err", resolve_err, e.err);
      chk("branch_cnt",  branch_cnt,  e.bc);
      chk("mispred_cnt", mispred_cnt, e.mc);
    end
  end

  task automatic step(input bit fv, input int pc, input int op, input int tgt,
                      input bit rv, input bit rt);
    exp_t e;
    bit   is_br, ready, pred, mp, hit;
    int   idx;
    ent_t h, n;
    @(posedge Clock); #1;
    Reset         = 0;
    fetch_valid   = fv;
    fetch_pc      = ADDR_W'(pc);
    fetch_instr   = (32'(op) << 26) | 32'(tgt & 255);
    resolve_valid = rv;
    resolve_taken = rt;

    is_br = fv && (op == OP_BEZ || op == OP_BNZ);
    ready = (mq.size() < INFL);
    idx   = (pc % 16) ^ mghr;
    pred  = is_br && ready && (mctr[idx] >= 2);
    hit   = rv && (mq.size() > 0);
    mp    = 0;
    e.rpc = 0;
    if (hit) begin
      h     = mq[0];
      mp    = (h.pred != rt);
      e.rpc = rt ? h.target : h.fall;
    end
    e.ready = ready; e.pt = pred; e.tgt = tgt & 255; e.mp = mp;
    e.err = rv && !hit; e.bc = mbc; e.mc = mmc;
    sbq.push_back(e);

    if (hit) begin
      void'(mq.pop_front());
      mctr[h.idx] = rt ? ((mctr[h.idx] < 3) ? mctr[h.idx] + 1 : 3)
                       : ((mctr[h.idx] > 0) ? mctr[h.idx] - 1 : 0);
      if (mbc < 65535) mbc++;
      if (mp && mmc < 65535) mmc++;
      if (mp) begin
        mq.delete();
        mghr = ((h.ghr * 2) + rt) % 4;
      end
    end
    if (is_br && ready && !mp) begin
      n.idx = idx; n.pred = pred; n.target = tgt & 255;
      n.fall = (pc + 1) % 256; n.ghr = mghr;
      mq.push_back(n);
      mghr = ((mghr * 2) + pred) % 4;
    end
  endtask

  task automatic do_reset();
    @(posedge Clock); #1;
    Reset = 1; fetch_valid = 0; resolve_valid = 0;
    model_reset();
  endtask

  task automatic idle(); step(0, 0, OP_NOP, 0, 0, 0); endtask

  int pcs[6] = '{'h10, 'h11, 'h01, 'h02, 'h03, 'hFF};

  initial begin
    model_reset();
    idle();
    // Mispredict a cold branch, then refetch it.
    step(1, 'h10, OP_BEZ, 'h40, 0, 0);
    step(0, 0, OP_NOP, 0, 1, 1);
    step(1, 'h10, OP_BEZ, 'h40, 0, 0);
    step(0, 0, OP_NOP, 0, 1, 1);
    // Drive one counter into saturation and back.
    repeat (6) begin
      step(1, 'h10, OP_BNZ, 'h40, 0, 0);
      step(0, 0, OP_NOP, 0, 1, 1);
    end
    step(1, 'h10, OP_BNZ, 'h40, 0, 0);
    step(0, 0, OP_NOP, 0, 1, 0);
    step(1, 'h10, OP_BNZ, 'h40, 0, 0);
    step(0, 0, OP_NOP, 0, 1, 0);
    // Fill the queue, fetch while full, then resolve while full with a fetched branch.
    step(1, 'h01, OP_BEZ, 'h20, 0, 0);
    step(1, 'h02, OP_BEZ, 'h21, 0, 0);
    step(1, 'h03, OP_BEZ, 'h22, 0, 0);
    step(1, 'h03, OP_BEZ, 'h22, 1, mq.size() > 0 ? mq[0].pred : 1'b0);
    step(1, 'h03, OP_BEZ, 'h22, 0, 0);
    step(0, 0, OP_NOP, 0, 1, 1);
    step(0, 0, OP_NOP, 0, 1, 1);
    // Head at 0xFF mispredicted not-taken with a younger entry behind it.
    step(0, 0, OP_NOP, 0, 1, 0);
    step(1, 'hFF, OP_BEZ, 'h30, 0, 0);
    step(1, 'h05, OP_BNZ, 'h31, 0, 0);
    step(1, 'h06, OP_BNZ, 'h32, 1, mq.size() > 0 ? !mq[0].pred : 1'b0);
    step(0, 0, OP_NOP, 0, 1, 0);
    step(0, 0, OP_NOP, 0, 1, 1);
    // Reset with entries in flight and nonzero perf counts.
    step(1, 'h07, OP_BEZ, 'h10, 0, 0);
    step(1, 'h08, OP_BEZ, 'h11, 0, 0);
    do_reset();
    idle();
    step(0, 0, OP_NOP, 0, 1, 1);

    for (int c = 0; c < 3000; c++) begin
      int  pc, op, r;
      bit  rv;
      r  = $urandom_range(0, 9);
      pc = (r < 7) ? pcs[$urandom_range(0, 5)] : int'($urandom_range(0, 255));
      r  = $urandom_range(0, 9);
      op = (r < 4) ? OP_BEZ : (r < 7) ? OP_BNZ : (r == 7) ? OP_LOAD : (r == 8) ? OP_ALU : OP_NOP;
      rv = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, pc, op, int'($urandom_range(0, 255)), rv,
                ($urandom_range(0, 3) != 0) ^ (pc[0] & ($urandom_range(0, 1) == 1)));
    end

    repeat (3) @(posedge Clock);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
